// File: rtl/execute_muldiv.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN: trivial multiplies/divides finish at accept.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for an op, in_ready=1
// MUL   | one shift-add step per cycle
// DIV   | one restoring-divide step per cycle
// DONE  | result valid, held until out_ready
module execute_muldiv #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             word,
  input  logic [XLEN-1:0]  src1,
  input  logic [XLEN-1:0]  src2,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]       op_q;
  logic             word_q;
  logic [XLEN-1:0]  a_q, hi_q, lo_q, result_q;
  logic             neg_a_q, neg_r_q;
  logic [CW-1:0]    cnt_q;
  logic [TAG_W-1:0] tag_q;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // Operand decode at issue
  logic            sgn1, sgn2, neg1, neg2;
  logic [XLEN-1:0] x1, x2, m1, m2, min_val, special_res, special_raw;
  logic            div_zero, div_ovf, early_zero, early_small, special;

  always_comb begin
    sgn1 = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    sgn2 = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    x1 = word ? (sgn1 ? sext32(src1[31:0]) : {{(XLEN-32){1'b0}}, src1[31:0]}) : src1;
    x2 = word ? (sgn2 ? sext32(src2[31:0]) : {{(XLEN-32){1'b0}}, src2[31:0]}) : src2;
    neg1 = sgn1 & x1[XLEN-1];
    neg2 = sgn2 & x2[XLEN-1];
    m1 = neg1 ? -x1 : x1;
    m2 = neg2 ? -x2 : x2;
    min_val = word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = op[2] && (x2 == '0);
    div_ovf  = op[2] && sgn2 && (x1 == min_val) && (x2 == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early_zero  = !op[2] && ((m1 == '0) || (m2 == '0));
    early_small = op[2] && (m1 < m2);
`else
    early_zero  = 1'b0;
    early_small = 1'b0;
`endif
    special = div_zero || div_ovf || early_zero || early_small;
    special_raw = '0;
    if (div_zero)         special_raw = op[1] ? x1 : '1;
    else if (div_ovf)     special_raw = op[1] ? '0 : x1;
    else if (early_small) special_raw = op[1] ? x1 : '0;
    special_res = word ? sext32(special_raw[31:0]) : special_raw;
  end

  // One iteration step for each algorithm
  logic [XLEN:0]     mul_sum, div_sh;
  logic [XLEN-1:0]   mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, div_diff;
  logic              div_ok, last;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res, quo, rem, fin, final_res;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : '0)};
    mul_hi_n = mul_sum[XLEN:1];
    mul_lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_ok   = div_sh >= {1'b0, a_q};
    div_diff = div_sh[XLEN-1:0] - a_q;
    div_hi_n = div_ok ? div_diff : div_sh[XLEN-1:0];
    div_lo_n = {lo_q[XLEN-2:0], div_ok};
    last     = cnt_q == (word_q ? CW'(31) : CW'(XLEN-1));

    // W multiplies only run 32 steps, leaving the product 32 bits high
    prod = {mul_hi_n, mul_lo_n};
    if (word_q)  prod = prod >> 32;
    if (neg_r_q) prod = -prod;
    mul_res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    quo = neg_r_q ? -div_lo_n : div_lo_n;
    rem = neg_a_q ? -div_hi_n : div_hi_n;
    fin = op_q[2] ? (op_q[1] ? rem : quo) : mul_res;
    final_res = word_q ? sext32(fin[31:0]) : fin;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (in_valid) state_nxt = special ? DONE : (op[2] ? DIV : MUL);
      MUL, DIV: if (last) state_nxt = DONE;
      DONE:     if (out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      word_q   <= 1'b0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      cnt_q    <= '0;
      tag_q    <= '0;
      result_q <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: if (in_valid) begin
          op_q    <= op;
          word_q  <= word;
          tag_q   <= tag_in;
          cnt_q   <= '0;
          neg_a_q <= neg1;
          neg_r_q <= neg1 ^ neg2;
          hi_q    <= '0;
          if (op[2]) begin
            a_q  <= m2;
            lo_q <= word ? (m1 << 32) : m1;
          end else begin
            a_q  <= m1;
            lo_q <= m2;
          end
          if (special) result_q <= special_res;
        end
        MUL: begin
          hi_q  <= mul_hi_n;
          lo_q  <= mul_lo_n;
          cnt_q <= cnt_q + CW'(1);
          if (last) result_q <= final_res;
        end
        DIV: begin
          hi_q  <= div_hi_n;
          lo_q  <= div_lo_n;
          cnt_q <= cnt_q + CW'(1);
          if (last) result_q <= final_res;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_q;
  assign tag_out   = tag_q;

endmodule
